// File: rtl/dt_sweep_driver.sv
// Exhaustive sweep engine: drives every classifier input in order and streams each {feature, class} pair out.
// Latency: first beat valid two cycles after start; one beat per cycle when m_ready stays high.
// Backpressure: a stalled beat holds the sweep in place, so each stall cycle adds exactly one cycle.
module dt_sweep_driver #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 3,
    parameter int CNT_W = IN_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IN_W-1:0]  feat_o,
    input  logic [OUT_W-1:0] cls_i,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IN_W-1:0]  m_feat,
    output logic [OUT_W-1:0] m_cls,
    input  logic [OUT_W-1:0] hist_sel,
    output logic [CNT_W-1:0] hist_cnt
);

    localparam int NCLS = 1 << OUT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [IN_W-1:0]    feat_q;
    logic               vld_q;
    logic [IN_W-1:0]    slot_feat_q;
    logic [OUT_W-1:0]   slot_cls_q;
    logic [CNT_W-1:0]   cnt_q [NCLS];

    logic               load_d;
    logic               last_d;
    logic               clear_d;

    // The slot accepts a new sample when it is empty or its beat is handshaking this cycle.
    always_comb begin
        load_d  = (state_q == S_RUN) && (!vld_q || m_ready);
        last_d  = &feat_q;
        clear_d = (state_q == S_IDLE) && start;
    end

    // Sweep sequencer; owns the feature counter, the output slot and the status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            feat_q      <= '0;
            vld_q       <= 1'b0;
            slot_feat_q <= '0;
            slot_cls_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        feat_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (load_d) begin
                        // cls_i is the classifier's answer for the feat_o driven this same cycle.
                        slot_feat_q <= feat_q;
                        slot_cls_q  <= cls_i;
                        vld_q       <= 1'b1;
                        if (last_d) begin
                            state_q <= S_DRAIN;
                        end else begin
                            feat_q <= feat_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Only the final beat remains; wait for it to be taken.
                    if (vld_q && m_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    // Per-class histogram: cleared on an accepted start, bumped once per loaded sample.
    // CNT_W holds 2^IN_W, so the counters cannot wrap within a sweep.
    always_ff @(posedge clk) begin
        if (rst || clear_d) begin
            for (int i = 0; i < NCLS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (load_d) begin
            cnt_q[cls_i] <= cnt_q[cls_i] + CNT_W'(1);
        end
    end

    // Histogram read port is a plain mux, so a new select is visible in the same cycle.
    always_comb begin
        hist_cnt = cnt_q[hist_sel];
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign feat_o  = feat_q;
    assign m_valid = vld_q;
    assign m_feat  = slot_feat_q;
    assign m_cls   = slot_cls_q;

endmodule

// File: tb/tb_dt_sweep_driver.sv
// Directed bench for the sweep driver with a small reference decision tree as the classifier.
// Latency: checks first-beat, done-cycle and per-stall timing against hand-derived cycle numbers.
// Backpressure: m_ready is driven from the bench, either held high or random at a chosen duty.
module tb_dt_sweep_driver;

    localparam int IN_W  = 12;
    localparam int OUT_W = 3;
    localparam int CNT_W = IN_W + 1;
    localparam int NBEAT = 1 << IN_W;

    logic             clk;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [IN_W-1:0]  feat_o;
    logic [OUT_W-1:0] cls_i;
    logic             m_valid;
    logic             m_ready;
    logic [IN_W-1:0]  m_feat;
    logic [OUT_W-1:0] m_cls;
    logic [OUT_W-1:0] hist_sel;
    logic [CNT_W-1:0] hist_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-class populations of the tree below, worked out by hand from its split conditions.
    int ref_cnt [8] = '{448, 448, 448, 448, 256, 640, 640, 768};

    dt_sweep_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .feat_o   (feat_o),
        .cls_i    (cls_i),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_feat   (m_feat),
        .m_cls    (m_cls),
        .hist_sel (hist_sel),
        .hist_cnt (hist_cnt)
    );

    // Attached classifier: a fixed decision tree over the 12-bit feature.
    function automatic logic [2:0] tree(input logic [11:0] x);
        if (x[11]) begin
            if (x[3:0] > 4'd9) return 3'd7;
            else if (x[7])     return 3'd6;
            else               return 3'd5;
        end else if (x[10:8] == 3'd3) begin
            return 3'd4;
        end else if (x[5] ^ x[2]) begin
            return x[1] ? 3'd3 : 3'd2;
        end else begin
            return x[0] ? 3'd1 : 3'd0;
        end
    endfunction

    assign cls_i = tree(feat_o);

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reads all eight counters through the select mux (1 time unit each, well inside the cycle).
    task automatic read_hist(output int cnt [8]);
        for (int k = 0; k < 8; k++) begin
            hist_sel = 3'(k);
            #1;
            cnt[k] = int'(hist_cnt);
        end
    endtask

    // Runs one sweep from IDLE. Returns in the DONE cycle, or right after reset when aborting.
    task automatic run_sweep(input int duty, input bit poke, input int abort_at);
        int   cyc;
        int   beats;
        int   order_bad;
        int   cls_bad;
        int   stab_bad;
        int   stalls;
        int   done_cyc;
        int   sum;
        int   cnt [8];
        bit   held;
        bit   poked;
        logic [IN_W-1:0]  hf;
        logic [OUT_W-1:0] hc;

        beats = 0; order_bad = 0; cls_bad = 0; stab_bad = 0; stalls = 0;
        done_cyc = 0; held = 1'b0; poked = 1'b0; hf = '0; hc = '0;

        start   = 1'b1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;

        check_eq("c1_busy", 32'(busy), 32'd1);
        check_eq("c1_feat_o", 32'(feat_o), 32'd0);
        check_eq("c1_valid", 32'(m_valid), 32'd0);
        read_hist(cnt);
        sum = 0;
        for (int k = 0; k < 8; k++) sum += cnt[k];
        check_eq("c1_hist_cleared", 32'(sum), 32'd0);

        forever begin
            start = 1'b0;
            if (cyc > 30000) begin
                check_eq("sweep_timeout", 32'd1, 32'd0);
                return;
            end
            if (held) begin
                if (!m_valid || m_feat !== hf || m_cls !== hc) stab_bad++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            m_ready = ($urandom_range(99, 0) < duty);

            if (abort_at >= 0 && m_valid && int'(m_feat) == abort_at) begin
                m_ready = 1'b0;
                @(posedge clk); #1;
                check_eq("abort_pending_valid", 32'(m_valid), 32'd1);
                check_eq("abort_pending_feat", 32'(m_feat), 32'(abort_at));
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_eq("abort_valid", 32'(m_valid), 32'd0);
                check_eq("abort_busy", 32'(busy), 32'd0);
                check_eq("abort_done", 32'(done), 32'd0);
                check_eq("abort_feat_o", 32'(feat_o), 32'd0);
                read_hist(cnt);
                sum = 0;
                for (int k = 0; k < 8; k++) sum += cnt[k];
                check_eq("abort_hist_sum", 32'(sum), 32'd0);
                return;
            end

            if (m_valid && m_ready) begin
                if (int'(m_feat) != beats) order_bad++;
                if (m_cls !== tree(m_feat)) cls_bad++;
                beats++;
                held = 1'b0;
            end else if (m_valid) begin
                held = 1'b1;
                hf = m_feat;
                hc = m_cls;
                stalls++;
            end else begin
                held = 1'b0;
            end

            if (poke && !poked && beats == 100) begin
                start = 1'b1;
                poked = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end

        check_eq("done_cycle", 32'(done_cyc), 32'(NBEAT + 2 + stalls));
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_valid", 32'(m_valid), 32'd0);
        check_eq("beat_count", 32'(beats), 32'(NBEAT));
        check_eq("beat_order_errs", 32'(order_bad), 32'd0);
        check_eq("beat_class_errs", 32'(cls_bad), 32'd0);
        check_eq("stall_stability_errs", 32'(stab_bad), 32'd0);
        read_hist(cnt);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("hist_%0d", k), 32'(cnt[k]), 32'(ref_cnt[k]));
        end
        m_ready = 1'b0;

        if (poke) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check_eq("poke_done_busy", 32'(busy), 32'd0);
            check_eq("poke_done_valid", 32'(m_valid), 32'd0);
            @(posedge clk); #1;
            check_eq("poke_idle_busy", 32'(busy), 32'd0);
            check_eq("poke_idle_feat_o", 32'(feat_o), 32'(NBEAT - 1));
            read_hist(cnt);
            check_eq("poke_hist_kept_7", 32'(cnt[7]), 32'd768);
            check_eq("poke_hist_kept_4", 32'(cnt[4]), 32'd256);
        end
    endtask

    initial begin
        int cnt [8];

        rst      = 1'b1;
        start    = 1'b0;
        m_ready  = 1'b0;
        hist_sel = '0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_feat", 32'(m_feat), 32'd0);
        check_eq("rst_m_cls", 32'(m_cls), 32'd0);
        check_eq("rst_feat_o", 32'(feat_o), 32'd0);
        read_hist(cnt);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("rst_hist_%0d", k), 32'(cnt[k]), 32'd0);
        end

        // Full sweep without backpressure.
        run_sweep(100, 1'b0, -1);
        @(posedge clk); #1;

        // Random backpressure at 30% ready duty.
        run_sweep(30, 1'b0, -1);
        @(posedge clk); #1;

        // start pulses while busy and in the DONE cycle.
        run_sweep(100, 1'b1, -1);
        @(posedge clk); #1;

        // Reset with beat 57 stalled, then a clean sweep.
        run_sweep(100, 1'b0, 57);
        @(posedge clk); #1;
        run_sweep(100, 1'b0, -1);

        // Back-to-back: start in the cycle right after DONE.
        @(posedge clk); #1;
        run_sweep(100, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dt_sweep_driver.md
# dt_sweep_driver

Sequential stimulus and collection engine that sits on the opposite side of a combinational decision-tree classifier from its consumers. It drives every feature vector of the classifier's input space in ascending order and samples the class code returned in the same cycle. Each (feature, class) pair is emitted on a valid/ready stream, and a per-class histogram is kept. It is the standard harness for exhaustively characterising and exporting a generated tree's truth table.

## Interface
Parameters:
- IN_W, 12, classifier feature-vector width.
- OUT_W, 3, classifier class-code width.
- CNT_W, IN_W+1, histogram counter width; must hold 2^IN_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep has completed.
- feat_o  output  IN_W  feature vector driven to the classifier `inp`; registered.
- cls_i  input  OUT_W  classifier `outp`; combinational function of feat_o, sampled same cycle.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready.
- m_feat  output  IN_W  feature of the current stream beat.
- m_cls  output  OUT_W  class of the current stream beat.
- hist_sel  input  OUT_W  histogram read select.
- hist_cnt  output  CNT_W  combinational read of counter[hist_sel].

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → clear all 2^OUT_W counters, feat_o←0, go RUN.
  - start=0 → hold.
- RUN: one output slot, made of m_valid/m_feat/m_cls.
  - Load condition: slot empty (m_valid=0) or m_ready=1.
  - On a load: slot←{feat_o, cls_i}, m_valid←1, counter[cls_i]+=1.
  - On a load with feat_o≠all-ones: feat_o+=1.
  - On a load with feat_o=all-ones: feat_o holds, go DRAIN.
  - No load: feat_o, slot and counters hold.
- DRAIN:
  - m_valid=1 and m_ready=1 → m_valid←0, go DONE.
  - No new loads occur.
- DONE: done=1 for exactly this cycle, then go IDLE. start is ignored in DONE.
- busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
- Stream rules:
  - m_feat and m_cls are stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - Exactly 2^IN_W beats per sweep, with m_feat = 0,1,…,2^IN_W−1 in order and no gaps or duplicates.
- Counters:
  - Saturation is unnecessary because CNT_W ≥ IN_W+1.
  - At DONE, the counters sum to 2^IN_W.
  - Counters retain their values in IDLE until the next start.
- start while busy: ignored; no restart and no counter clear.
- rst at any time, including mid-sweep with a stalled beat: state←IDLE, discards the pending beat without a handshake.

## Timing
- Reset values:
  - busy=0, done=0, m_valid=0, m_feat=0, m_cls=0, feat_o=0.
  - All counters=0, so hist_cnt=0.
- start sampled at edge T0:
  - RUN, busy=1, feat_o=0 visible in cycle 1.
  - First beat (m_feat=0) valid in cycle 2.
- With m_ready held high:
  - One beat per cycle.
  - Last beat (all-ones) valid in cycle 2^IN_W+1; handshake there.
  - done=1 in cycle 2^IN_W+2; busy=0 in that cycle.
- Backpressure adds exactly one cycle per stalled cycle; no throughput loss after m_ready returns.
- hist_cnt has zero latency from hist_sel. A counter updated by a load at edge T reads the new value from cycle T+1.
- The classifier path (feat_o→cls_i) must close within one clock period. No pipelining of cls_i is permitted.

## Test plan
- Reset then idle:
  - Stimulus: assert rst 2 cycles, hold start=0 for 10 cycles.
  - Required: all outputs 0, hist_cnt=0 for every hist_sel.
- Full sweep, no backpressure:
  - Stimulus: pulse start, m_ready=1.
  - Required: 4096 beats with m_feat=0..4095 contiguous, each m_cls equal to a reference model of the attached tree.
  - Required: done in cycle 4098 after start; the 8 counters sum to 4096 and match per-class model counts.
- Random backpressure:
  - Stimulus: m_ready random at 30% duty.
  - Required: beat order and content identical to the no-backpressure sweep; m_feat and m_cls stable during every stall; counters identical.
- start while busy:
  - Stimulus: pulse start at beat 100 and again in the DONE cycle.
  - Required: no restart, beat count stays 4096, counters not cleared, state IDLE after DONE.
- Reset mid-sweep:
  - Stimulus: m_ready=0 with beat 57 pending, then rst.
  - Required: next cycle m_valid=0, busy=0, counters=0.
  - Then a new start yields a clean full sweep beginning at m_feat=0.
- Back-to-back sweeps:
  - Stimulus: start the cycle after DONE.
  - Required: counters cleared, then re-accumulated to the same totals; second sweep identical to the first.
